// File: rtl/sys_bus_ctrl_pkg.sv
// Shared definitions for the system bus controller: region encoding, id sizing and
// the read-response tag carried through the data-return pipeline.
package sys_bus_ctrl_pkg;

    localparam logic       REGION_RAM = 1'b0;
    localparam logic       REGION_IO  = 1'b1;
    localparam logic [1:0] IO_WINDOW  = 2'b11;

    // Tags are sized for the largest supported master count (8).
    localparam int unsigned MAX_ID_W = 3;

    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
        logic                is_io;
    } rsp_tag_t;

endpackage

// File: rtl/sys_bus_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among eligible requesters, search starting at the
// pointer, pointer advances past the winner unless held.
module sys_bus_ctrl_rr_arbiter
    import sys_bus_ctrl_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 2
) (
    input  logic                                clk_in,
    input  logic                                rst_n_in,
    input  logic [NUM_MASTERS-1:0]              req,
    input  logic [NUM_MASTERS-1:0]              eligible,
    input  logic                                ptr_hold,
    output logic [NUM_MASTERS-1:0]              grant,
    output logic [id_width(NUM_MASTERS)-1:0]    grant_id,
    output logic                                grant_any
);

    localparam int unsigned IdW = id_width(NUM_MASTERS);
    localparam int          N   = int'(NUM_MASTERS);

    logic [IdW-1:0] rr_ptr_q, rr_ptr_d;

    always_comb begin
        int idx;
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int off = 0; off < N; off++) begin
            idx = (int'(rr_ptr_q) + off) % N;
            if (!grant_any && req[idx] && eligible[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = IdW'(idx);
                grant_any  = 1'b1;
            end
        end
    end

    always_comb begin
        int nxt;
        nxt = int'(grant_id) + 1;
        if (nxt >= N) begin
            nxt = 0;
        end
        rr_ptr_d = rr_ptr_q;
        if (grant_any && !ptr_hold) begin
            rr_ptr_d = IdW'(nxt);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/sys_bus_ctrl.sv
// System memory-bus controller: reset stretcher, round-robin master arbitration with
// debug pause, RAM/IO decode and a two-stage tracked read-data return path.
module sys_bus_ctrl
    import sys_bus_ctrl_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 2,
    parameter int unsigned RAM_ADDR_WIDTH = 17,
    parameter int unsigned DBG_MASTER     = 1,
    parameter int unsigned RST_STAGES     = 2
) (
    input  logic                        clk_in,
    input  logic                        rst_n_in,
    output logic                        sys_rst_out,
    input  logic                        dbg_active_in,
    input  logic [NUM_MASTERS-1:0]      req_valid,
    output logic [NUM_MASTERS-1:0]      req_ready,
    input  logic [NUM_MASTERS*32-1:0]   req_addr,
    input  logic [NUM_MASTERS-1:0]      req_wr,
    input  logic [NUM_MASTERS*8-1:0]    req_wdata,
    output logic [NUM_MASTERS-1:0]      rsp_valid,
    output logic [7:0]                  rsp_data,
    output logic [RAM_ADDR_WIDTH:0]     mem_a,
    output logic                        mem_wr,
    output logic [7:0]                  mem_dout,
    output logic                        ram_en,
    output logic                        io_en,
    input  logic [7:0]                  ram_din,
    input  logic [7:0]                  io_din
);

    localparam int unsigned IdW = id_width(NUM_MASTERS);
    localparam logic [NUM_MASTERS-1:0] DbgMask = NUM_MASTERS'(1) << DBG_MASTER;

    // Shift-register synchroniser doubles as the stretch counter.
    logic [RST_STAGES-1:0] rst_sync_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[RST_STAGES-2:0], 1'b1};
        end
    end

    assign sys_rst_out = ~rst_sync_q[RST_STAGES-1];

    logic [NUM_MASTERS-1:0] eligible;
    logic [NUM_MASTERS-1:0] grant;
    logic [IdW-1:0]         grant_id;
    logic                   grant_any;

    always_comb begin
        eligible = '1;
        if (sys_rst_out) begin
            eligible = '0;
        end else if (dbg_active_in) begin
            eligible = DbgMask;
        end
    end

    sys_bus_ctrl_rr_arbiter #(
        .NUM_MASTERS(NUM_MASTERS)
    ) u_arbiter (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .req       (req_valid),
        .eligible  (eligible),
        .ptr_hold  (dbg_active_in),
        .grant     (grant),
        .grant_id  (grant_id),
        .grant_any (grant_any)
    );

    assign req_ready = grant;

    logic [31:0] sel_addr;
    logic        sel_wr;
    logic [7:0]  sel_wdata;
    logic        sel_region;
    logic        unused_addr;

    assign sel_addr    = req_addr[32*int'(grant_id) +: 32];
    assign sel_wr      = req_wr[grant_id];
    assign sel_wdata   = req_wdata[8*int'(grant_id) +: 8];
    assign sel_region  = (sel_addr[RAM_ADDR_WIDTH -: 2] == IO_WINDOW) ? REGION_IO : REGION_RAM;
    assign unused_addr = ^sel_addr[31:RAM_ADDR_WIDTH+1];

    rsp_tag_t s1_tag_q, s2_tag_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            mem_a    <= '0;
            mem_wr   <= 1'b0;
            mem_dout <= '0;
            ram_en   <= 1'b0;
            io_en    <= 1'b0;
            s1_tag_q <= '0;
            s2_tag_q <= '0;
        end else begin
            if (grant_any) begin
                mem_a          <= sel_addr[RAM_ADDR_WIDTH:0];
                mem_wr         <= sel_wr;
                mem_dout       <= sel_wdata;
                io_en          <= (sel_region == REGION_IO);
                ram_en         <= (sel_region == REGION_RAM);
                s1_tag_q.valid <= ~sel_wr;
                s1_tag_q.id    <= MAX_ID_W'(grant_id);
                s1_tag_q.is_io <= (sel_region == REGION_IO);
            end else begin
                mem_wr   <= 1'b0;
                ram_en   <= 1'b0;
                io_en    <= 1'b0;
                s1_tag_q <= '0;
            end
            s2_tag_q <= s1_tag_q;
        end
    end

    // Read data is steered straight from the bus, not retimed.
    always_comb begin
        rsp_valid = '0;
        rsp_data  = 8'h00;
        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            rsp_valid[i] = s2_tag_q.valid && (s2_tag_q.id == MAX_ID_W'(i));
        end
        if (s2_tag_q.valid) begin
            rsp_data = s2_tag_q.is_io ? io_din : ram_din;
        end
    end

endmodule

// File: doc/sys_bus_ctrl.md
Name: sys_bus_ctrl

Overview:
- Parametrised system memory-bus controller and reset sequencer.
- Arbitrates NUM_MASTERS byte-wide requesters (CPU, HCI, future DMA) onto the single RAM/IO bus.
- Decodes each access to RAM or the IO window and returns read data to the issuing master through a tracked pipeline.
- Supports debug-pause mode: while debug is active, only the debug master is granted.

Parameters:
NUM_MASTERS, 2, number of requesters (1..8)
RAM_ADDR_WIDTH, 17, RAM address bits; IO window is addr[RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1]==2'b11
DBG_MASTER, 1, index of the master that keeps grant rights while dbg_active_in=1
RST_STAGES, 2, cycles sys_rst_out stays high after rst_n_in deasserts (>=2)

Ports:
clk_in  in  1  system clock
rst_n_in  in  1  async active-low reset
sys_rst_out  out  1  active-high stretched reset for downstream blocks
dbg_active_in  in  1  debug break; pauses all masters except DBG_MASTER
req_valid  in  NUM_MASTERS  per-master request
req_ready  out  NUM_MASTERS  per-master grant (combinational, one-hot or zero)
req_addr  in  NUM_MASTERS*32  per-master byte address, master i at [32*i+31:32*i]
req_wr  in  NUM_MASTERS  1=write, 0=read
req_wdata  in  NUM_MASTERS*8  per-master write byte
rsp_valid  out  NUM_MASTERS  one-cycle read-data strobe to the issuing master
rsp_data  out  8  read data, shared by all masters
mem_a  out  RAM_ADDR_WIDTH+1  registered bus address
mem_wr  out  1  registered write strobe
mem_dout  out  8  registered write data
ram_en  out  1  registered RAM enable
io_en  out  1  registered IO enable
ram_din  in  8  RAM read data (valid the cycle after ram_en)
io_din  in  8  IO read data (same timing as ram_din)

Behaviour:
- Reset:
  - rst_n_in low asynchronously sets sys_rst_out=1, clears the stretch counter, the RR pointer (=0) and both pipeline stages.
  - While in reset, req_ready=0, rsp_valid=0, mem_a=0, mem_wr=0, mem_dout=0, ram_en=0, io_en=0.
- Reset release:
  - Deassertion is synchronised.
  - sys_rst_out falls on the RST_STAGES-th rising edge after rst_n_in goes high.
  - No grants are issued while sys_rst_out=1.
- Handshake:
  - A transfer occurs in cycle T when req_valid[i] & req_ready[i].
  - The master holds addr/wr/wdata stable until accepted.
  - At most one grant per cycle; a new grant is allowed every cycle (full throughput).
- Arbitration:
  - Round-robin; search starts at rr_ptr.
  - On a grant to master g, rr_ptr <= (g+1) mod NUM_MASTERS; with no grant, rr_ptr holds.
- Debug pause:
  - While dbg_active_in=1, only DBG_MASTER is eligible; all other req_ready=0.
  - rr_ptr is untouched while paused.
  - dbg_active_in changes take effect in the same cycle (combinational).
- Stage 1 (edge ending T): register mem_a=addr[RAM_ADDR_WIDTH:0], mem_wr, mem_dout.
  - io_en=1 if the region bits are 2'b11, else ram_en=1.
  - With no grant: ram_en=io_en=mem_wr=0; mem_a/mem_dout hold their last values.
- Stage 2 (edge ending T+1): for reads only, latch {valid, master id, is_io}.
- Read response:
  - In cycle T+2, rsp_valid[id]=1 and rsp_data = is_io ? io_din : ram_din (combinational mux).
  - Read latency is 2 cycles from acceptance.
  - Writes produce no response.
- Back-to-back reads from different masters return in issue order, one per cycle.
- Data is not retimed: rsp_data = 0 when no response is due.
- Address bits above RAM_ADDR_WIDTH are ignored.
- Reset mid-transfer: in-flight reads are dropped (no rsp_valid). The bus must be idle again on the first cycle after reset is released.

Decomposition:
- Shared package holds:
  - region encoding constants (REGION_RAM=1'b0, REGION_IO=1'b1) and the IO window tag 2'b11;
  - the master-id width function clog2(NUM_MASTERS);
  - a response-tag typedef {valid, id, is_io}.
- One natural sub-module: rr_arbiter (NUM_MASTERS requests + eligibility mask in, one-hot grant out, pointer update).
- The reset stretcher stays inline.

Test Plan:
- Reset: rst_n_in low 3 cycles, then high with RST_STAGES=2 -> sys_rst_out falls on the 2nd edge; req_valid=2'b11 held throughout -> req_ready=0 until then, all bus outputs 0.
- Contention: both masters request reads of 0x00010 continuously -> grants alternate M0,M1,M0,...; ram_en=1 each cycle; rsp_valid alternates 2'b01/2'b10 two cycles after each grant, with rsp_data=ram_din.
- IO decode: M0 writes 0x41 to 0x30000 -> io_en=1, ram_en=0, mem_wr=1, mem_dout=0x41, mem_a=0x30000; no rsp_valid.
- IO read: M0 reads 0x30004 with io_din=0x5A -> rsp_valid=2'b01 and rsp_data=0x5A at T+2.
- Debug pause: dbg_active_in=1 with both requesting -> only M1 (DBG_MASTER) granted each cycle; drop dbg_active_in -> M0 is granted next if rr_ptr=0.
- Reset mid-read: assert rst_n_in low one cycle after a read grant -> no rsp_valid ever; bus idle after release.
